// File: rtl/a2d_sched.sv
// Conversion scheduler for the shared A2D converter: arbitrates torque, motor-current
// and battery-voltage requests, runs the start/complete handshake and guards against a stuck converter.
module a2d_sched #(
    parameter int          FAST_SIM  = 0,
    parameter logic [2:0]  CH_TORQUE = 3'd2,
    parameter logic [2:0]  CH_CURR   = 3'd0,
    parameter logic [2:0]  CH_BATT   = 3'd4,
    parameter logic [15:0] TIMEOUT   = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cadence_rise,
    input  logic        not_pedaling,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] torque,
    output logic [11:0] curr,
    output logic [11:0] batt,
    output logic        torque_vld,
    output logic        curr_vld,
    output logic        batt_vld,
    output logic        a2d_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_TORQUE = 2'd0;
    localparam logic [1:0] OWN_CURR   = 2'd1;
    localparam logic [1:0] OWN_BATT   = 2'd2;

    state_t      state_q;
    logic [1:0]  owner_q;
    logic [15:0] tmo_q;
    logic [19:0] timer_q, timer_d;
    logic [2:0]  wrap_cnt_q, wrap_cnt_d;
    logic        torque_pend_q, torque_pend_d;
    logic        curr_pend_q, curr_pend_d;
    logic        batt_pend_q, batt_pend_d;

    logic        wrap_s;
    logic        grant_s;
    logic        grant_torque_s, grant_curr_s, grant_batt_s;
    logic [2:0]  grant_ch_s;
    logic [1:0]  grant_own_s;

    // Period timer wrap detection, request arbitration and pending-flag next state
    always_comb begin
        wrap_s         = 1'b0;
        grant_torque_s = 1'b0;
        grant_curr_s   = 1'b0;
        grant_batt_s   = 1'b0;
        grant_ch_s     = CH_TORQUE;
        grant_own_s    = OWN_TORQUE;

        if (FAST_SIM != 0) begin
            wrap_s = (timer_q[11:0] == 12'hFFF);
        end else begin
            wrap_s = (timer_q == 20'hF_FFFF);
        end

        timer_d = timer_q + 20'd1;
        if (wrap_s) begin
            wrap_cnt_d = wrap_cnt_q + 3'd1;
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end

        grant_s = (state_q == IDLE) && (torque_pend_q || curr_pend_q || batt_pend_q);
        if (torque_pend_q) begin
            grant_torque_s = grant_s;
            grant_ch_s     = CH_TORQUE;
            grant_own_s    = OWN_TORQUE;
        end else if (curr_pend_q) begin
            grant_curr_s   = grant_s;
            grant_ch_s     = CH_CURR;
            grant_own_s    = OWN_CURR;
        end else begin
            grant_batt_s   = grant_s;
            grant_ch_s     = CH_BATT;
            grant_own_s    = OWN_BATT;
        end

        // A set on the same edge as a grant or stop-clear wins, so no request is lost
        torque_pend_d = (cadence_rise && !not_pedaling)
                      || (torque_pend_q && !grant_torque_s && !not_pedaling);
        curr_pend_d   = wrap_s || (curr_pend_q && !grant_curr_s);
        batt_pend_d   = (wrap_s && (wrap_cnt_q == 3'd7)) || (batt_pend_q && !grant_batt_s);
    end

    // Period timer, wrap counter and pending request flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q       <= 20'd0;
            wrap_cnt_q    <= 3'd0;
            torque_pend_q <= 1'b0;
            curr_pend_q   <= 1'b0;
            batt_pend_q   <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            wrap_cnt_q    <= wrap_cnt_d;
            torque_pend_q <= torque_pend_d;
            curr_pend_q   <= curr_pend_d;
            batt_pend_q   <= batt_pend_d;
        end
    end

    // Conversion handshake FSM with its registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_TORQUE;
            tmo_q      <= 16'd0;
            strt_cnv   <= 1'b0;
            chnnl      <= 3'd0;
            torque     <= 12'h000;
            curr       <= 12'h000;
            batt       <= 12'h000;
            torque_vld <= 1'b0;
            curr_vld   <= 1'b0;
            batt_vld   <= 1'b0;
            a2d_err    <= 1'b0;
        end else begin
            strt_cnv   <= 1'b0;
            torque_vld <= 1'b0;
            curr_vld   <= 1'b0;
            batt_vld   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_s) begin
                        chnnl    <= grant_ch_s;
                        owner_q  <= grant_own_s;
                        strt_cnv <= 1'b1;
                        state_q  <= START;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                START: begin
                    tmo_q   <= 16'd0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnv_cmplt) begin
                        case (owner_q)
                            OWN_TORQUE: begin
                                torque     <= res;
                                torque_vld <= 1'b1;
                            end
                            OWN_CURR: begin
                                curr       <= res;
                                curr_vld   <= 1'b1;
                            end
                            OWN_BATT: begin
                                batt       <= res;
                                batt_vld   <= 1'b1;
                            end
                            default: begin
                                torque_vld <= 1'b0;
                            end
                        endcase
                        a2d_err <= 1'b0;
                        state_q <= IDLE;
                    end else if (tmo_q == (TIMEOUT - 16'd1)) begin
                        // Stuck converter: flag it and drop this request
                        a2d_err <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q   <= tmo_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sched.sv
// Directed-plus-random bench for a2d_sched: the bench acts as the A2D converter and
// checks schedule order, timing, result routing, timeout and reset behaviour against its own model.
module tb_a2d_sched;

    localparam int         TMO   = 64;
    localparam logic [2:0] CH_T  = 3'd2;
    localparam logic [2:0] CH_C  = 3'd0;
    localparam logic [2:0] CH_B  = 3'd4;
    localparam int         WRAP  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cadence_rise = 1'b0;
    logic        not_pedaling = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = 12'h000;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] torque, curr, batt;
    logic        torque_vld, curr_vld, batt_vld;
    logic        a2d_err;

    int checks = 0;
    int failures = 0;
    int cyc;
    logic [11:0] exp_t, exp_c, exp_b;

    a2d_sched #(
        .FAST_SIM (1),
        .TIMEOUT  (16'(TMO))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cadence_rise (cadence_rise),
        .not_pedaling (not_pedaling),
        .cnv_cmplt    (cnv_cmplt),
        .res          (res),
        .strt_cnv     (strt_cnv),
        .chnnl        (chnnl),
        .torque       (torque),
        .curr         (curr),
        .batt         (batt),
        .torque_vld   (torque_vld),
        .curr_vld     (curr_vld),
        .batt_vld     (batt_vld),
        .a2d_err      (a2d_err)
    );

    always #5 clk = ~clk;

    // Edges since reset release: a wrap falls on every multiple of WRAP
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vld_sum();
        return 32'(torque_vld) + 32'(curr_vld) + 32'(batt_vld);
    endfunction

    function automatic logic vld_of(input logic [2:0] ch);
        if (ch == CH_T)      return torque_vld;
        else if (ch == CH_C) return curr_vld;
        else                 return batt_vld;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_torque"}, 32'(torque), 32'(exp_t));
        chk({tag, "_curr"},   32'(curr),   32'(exp_c));
        chk({tag, "_batt"},   32'(batt),   32'(exp_b));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cadence_rise = 1'b0;
        not_pedaling = 1'b0;
        cnv_cmplt = 1'b0;
        res = 12'h000;
        tick();
        tick();
        rst = 1'b0;
        exp_t = 12'h000;
        exp_c = 12'h000;
        exp_b = 12'h000;
    endtask

    task automatic pulse_cad();
        cadence_rise = 1'b1;
        tick();
        cadence_rise = 1'b0;
    endtask

    task automatic wait_start(input string tag, output logic [2:0] ch, output int at);
        bit got = 1'b0;
        ch = 3'd0;
        at = -1;
        for (int n = 0; n < 6000 && !got; n++) begin
            if (strt_cnv === 1'b1) begin
                got = 1'b1;
                ch = chnnl;
                at = cyc;
            end else begin
                tick();
            end
        end
        chk({tag, "_start_seen"}, 32'(got), 32'd1);
    endtask

    task automatic complete(input string tag, input int dly, input logic [11:0] r, input logic [2:0] ch);
        for (int i = 0; i < dly; i++) tick();
        chk({tag, "_chnnl_stable"}, 32'(chnnl), 32'(ch));
        cnv_cmplt = 1'b1;
        res = r;
        tick();
        cnv_cmplt = 1'b0;
        res = 12'($urandom);
        if (ch == CH_T)      exp_t = r;
        else if (ch == CH_C) exp_c = r;
        else                 exp_b = r;
        check_regs(tag);
        chk({tag, "_vld"}, 32'(vld_of(ch)), 32'd1);
        chk({tag, "_vld_onehot"}, vld_sum(), 32'd1);
        chk({tag, "_err_clear"}, 32'(a2d_err), 32'd0);
        tick();
        chk({tag, "_vld_pulse"}, vld_sum(), 32'd0);
    endtask

    task automatic count_starts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (strt_cnv === 1'b1) cnt++;
            tick();
        end
    endtask

    initial begin
        logic [2:0]  ch;
        int          at, s_at, rise_at, nvld, extra, done_cyc, n0;
        logic [2:0]  exp_seq [$];

        // Reset state and a single torque conversion
        do_reset();
        chk("rst_strt", 32'(strt_cnv), 32'd0);
        chk("rst_chnnl", 32'(chnnl), 32'd0);
        chk("rst_vld", vld_sum(), 32'd0);
        chk("rst_err", 32'(a2d_err), 32'd0);
        check_regs("rst");
        tick();
        tick();
        pulse_cad();
        n0 = cyc;
        chk("t1_strt_early", 32'(strt_cnv), 32'd0);
        tick();
        chk("t1_strt", 32'(strt_cnv), 32'd1);
        chk("t1_strt_at", 32'(cyc), 32'(n0 + 1));
        chk("t1_chnnl", 32'(chnnl), 32'(CH_T));
        complete("t1", 10, 12'hABC, CH_T);

        // Periodic schedule over eight timer wraps
        do_reset();
        for (int w = 1; w <= 8; w++) begin
            exp_seq.push_back(CH_C);
            if (w % 8 == 0) exp_seq.push_back(CH_B);
        end
        for (int k = 0; k < exp_seq.size(); k++) begin
            wait_start("t2", ch, at);
            chk("t2_seq_ch", 32'(ch), 32'(exp_seq[k]));
            if (k == 0) chk("t2_first_at", 32'(at), 32'(WRAP + 1));
            complete("t2", int'($urandom_range(40, 1)), 12'($urandom), ch);
        end
        count_starts(8 * WRAP + 3000 - cyc, extra);
        chk("t2_no_extra", 32'(extra), 32'd0);

        // Wrap and cadence on the same edge: torque first, then current right after
        do_reset();
        while (cyc < WRAP - 1) tick();
        pulse_cad();
        wait_start("t3a", ch, at);
        chk("t3_first_ch", 32'(ch), 32'(CH_T));
        chk("t3_first_at", 32'(at), 32'(WRAP + 1));
        complete("t3a", int'($urandom_range(20, 1)), 12'($urandom), ch);
        done_cyc = cyc;
        wait_start("t3b", ch, at);
        chk("t3_second_ch", 32'(ch), 32'(CH_C));
        chk("t3_second_at", 32'(at), 32'(done_cyc));
        complete("t3b", int'($urandom_range(20, 1)), 12'($urandom), ch);
        count_starts(300, extra);
        chk("t3_no_extra", 32'(extra), 32'd0);

        // Two cadence rises while current is converting yield one torque conversion
        do_reset();
        wait_start("t4a", ch, at);
        chk("t4_curr_ch", 32'(ch), 32'(CH_C));
        tick();
        tick();
        pulse_cad();
        tick();
        pulse_cad();
        complete("t4a", 5, 12'($urandom), CH_C);
        wait_start("t4b", ch, at);
        chk("t4_torque_ch", 32'(ch), 32'(CH_T));
        complete("t4b", int'($urandom_range(20, 1)), 12'($urandom), ch);
        count_starts(300, extra);
        chk("t4_single", 32'(extra), 32'd0);

        // Converter timeout, late completion ignored, recovery clears the error
        do_reset();
        pulse_cad();
        wait_start("t5a", ch, at);
        complete("t5a", 3, 12'h5A5, CH_T);
        pulse_cad();
        wait_start("t5b", ch, s_at);
        rise_at = -1;
        nvld = 0;
        for (int i = 0; i < 4 * TMO && rise_at < 0; i++) begin
            tick();
            nvld += int'(vld_sum());
            if (a2d_err === 1'b1) rise_at = cyc;
        end
        chk("t5_err_delay", 32'(rise_at - s_at), 32'(TMO + 1));
        chk("t5_no_vld", 32'(nvld), 32'd0);
        check_regs("t5_timeout");
        cnv_cmplt = 1'b1;
        res = 12'hFFF;
        tick();
        cnv_cmplt = 1'b0;
        tick();
        check_regs("t5_late");
        chk("t5_err_held", 32'(a2d_err), 32'd1);
        pulse_cad();
        wait_start("t5c", ch, at);
        chk("t5_err_at_start", 32'(a2d_err), 32'd1);
        complete("t5c", int'($urandom_range(20, 1)), 12'($urandom), ch);

        // not_pedaling blocks torque; reset mid-conversion aborts it
        do_reset();
        not_pedaling = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse_cad();
            tick();
        end
        count_starts(40, extra);
        chk("t6_blocked", 32'(extra), 32'd0);
        not_pedaling = 1'b0;
        pulse_cad();
        wait_start("t6", ch, at);
        chk("t6_ch", 32'(ch), 32'(CH_T));
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_strt", 32'(strt_cnv), 32'd0);
        chk("t6_rst_chnnl", 32'(chnnl), 32'd0);
        chk("t6_rst_err", 32'(a2d_err), 32'd0);
        tick();
        rst = 1'b0;
        cnv_cmplt = 1'b1;
        res = 12'hABC;
        tick();
        cnv_cmplt = 1'b0;
        chk("t6_late_vld", vld_sum(), 32'd0);
        check_regs("t6_late");
        count_starts(40, extra);
        chk("t6_idle", 32'(extra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
